// File: rtl/mips_alu_exec_pkg.sv
// Shared ALU select codes and the multiply/divide sequencer state type.
package mips_alu_exec_pkg;

  localparam logic [3:0] ALU_AND      = 4'd0;
  localparam logic [3:0] ALU_OR       = 4'd1;
  localparam logic [3:0] ALU_ADD      = 4'd2;
  localparam logic [3:0] ALU_MULT     = 4'd3;
  localparam logic [3:0] ALU_DIV      = 4'd4;
  localparam logic [3:0] ALU_LUI      = 4'd5;
  localparam logic [3:0] ALU_SUB      = 4'd6;
  localparam logic [3:0] ALU_SLT      = 4'd7;
  localparam logic [3:0] ALU_UNMAPPED = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } md_state_t;

endpackage

// File: rtl/mips_alu_exec_muldiv_iter.sv
// Iterative signed multiply (shift-add) and restoring divide on operand magnitudes,
// with the sign correction applied in FIN.
//
// state | meaning
// IDLE  | waiting for a MULT/DIV issue
// MUL   | one shift-add step per cycle, WIDTH steps
// DIV   | one restoring-divide step per cycle, WIDTH steps
// FIN   | sign-corrected hi/lo presented; top loads them on leaving FIN
module mips_muldiv_iter
  import mips_alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int CW = $clog2(WIDTH);

  md_state_t        state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] mag_m;
  logic [WIDTH-1:0] a_save;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             div0;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_m} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mag_m};
  assign div_diff  = div_shift - {1'b0, mag_m};
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_mul)      state_nxt = ST_MUL;
        else if (start_div) state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: if (cnt == '0) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      mag_m   <= '0;
      a_save  <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_mul || start_div) begin
            cnt     <= CW'(WIDTH-1);
            is_div  <= ~start_mul;
            neg_res <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_rem <= op_a[WIDTH-1];
            div0    <= ~start_mul && (op_b == '0);
            a_save  <= op_a;
            if (start_mul) begin
              mag_m <= mag_a;
              acc   <= {{WIDTH{1'b0}}, mag_b};
            end else begin
              mag_m <= mag_b;
              acc   <= {{WIDTH{1'b0}}, mag_a};
            end
          end
        end
        ST_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ST_DIV: begin
          acc <= {div_rem, acc[WIDTH-2:0], div_ge};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    busy   = (state != ST_IDLE);
    fin    = (state == ST_FIN);
    hi_res = prod_fix[2*WIDTH-1:WIDTH];
    lo_res = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (div0) begin
        hi_res = a_save;
        lo_res = '1;
      end else begin
        hi_res = rem_fix;
        lo_res = quo_fix;
      end
    end
  end

endmodule

// File: rtl/mips_alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops plus an iterative MULT/DIV unit
// behind a start/busy/done handshake.
module mips_alu_exec
  import mips_alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  logic             issue;
  logic             start_mul, start_div, start_simple;
  logic             md_fin;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] simple_res;

  assign issue        = start & ~busy;
  assign start_mul    = issue && (alu_sel == ALU_MULT);
  assign start_div    = issue && (alu_sel == ALU_DIV);
  assign start_simple = issue && !start_mul && !start_div;

  mips_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_mul (start_mul),
    .start_div (start_div),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .fin       (md_fin),
    .hi_res    (md_hi),
    .lo_res    (md_lo)
  );

  always_comb begin
    simple_res = '0;
    if (alu_sel < ALU_UNMAPPED) begin
      case (alu_sel)
        ALU_AND: simple_res = op_a & op_b;
        ALU_OR:  simple_res = op_a | op_b;
        ALU_ADD: simple_res = op_a + op_b;
        ALU_SUB: simple_res = op_a - op_b;
        ALU_LUI: simple_res = op_b << 16;
        ALU_SLT: simple_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        default: simple_res = '0;
      endcase
    end
  end

  // hi/lo only move on MULT/DIV completion; simple ops touch result/zero only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b1;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else if (md_fin) begin
      hi     <= md_hi;
      lo     <= md_lo;
      result <= md_lo;
      zero   <= (md_lo == '0);
      done   <= 1'b1;
    end else if (start_simple) begin
      result <= simple_res;
      zero   <= (simple_res == '0);
      done   <= 1'b1;
    end else begin
      done   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_alu_exec.sv
// Scoreboard bench for mips_alu_exec: issue pushes expectations, a monitor checks on done.
module tb_mips_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_sel;
  logic [31:0] op_a, op_b;
  logic [31:0] result, hi, lo;
  logic        zero, busy, done;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  mips_alu_exec #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .alu_sel (alu_sel),
    .op_a    (op_a),
    .op_b    (op_b),
    .result  (result),
    .zero    (zero),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  // called at a negedge; returns one negedge later with start deasserted
  task automatic issue(input int id, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic md, input logic [31:0] hi_e, input logic [31:0] lo_e);
    exp_t e;
    start = 1'b1; alu_sel = sel; op_a = a; op_b = b;
    if (md) begin hi_m = hi_e; lo_m = lo_e; end
    e.id = id; e.res = res; e.hi = hi_m; e.lo = lo_m;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("op%0d_timeout", id), {31'b0, n < 200}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("op%0d_result", e.id), result, e.res);
        chk($sformatf("op%0d_zero", e.id), {31'b0, zero}, {31'b0, e.res == 32'd0});
        chk($sformatf("op%0d_hi", e.id), hi, e.hi);
        chk($sformatf("op%0d_lo", e.id), lo, e.lo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int n;
    rst_n = 1'b0; start = 1'b0; alu_sel = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset asserted in the middle of a MULT discards it
    start = 1'b1; alu_sel = 4'd3; op_a = 32'd100; op_b = 32'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midmul_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_zero", {31'b0, zero}, 32'd1);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1, 4'd2, 32'd5, 32'd7, 32'd12, 1'b0, '0, '0);
    chk("add_done_latency", {31'b0, done}, 32'd1);
    chk("add_busy", {31'b0, busy}, 32'd0);

    // back-to-back simple ops
    issue(2, 4'd0, 32'hFF00FF0F, 32'h0000000F, 32'h0000000F, 1'b0, '0, '0);
    issue(3, 4'd1, 32'hF0F00000, 32'h000000F0, 32'hF0F000F0, 1'b0, '0, '0);
    issue(4, 4'd6, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, '0, '0);
    issue(5, 4'd7, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, '0, '0);
    issue(6, 4'd7, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, '0, '0);
    issue(7, 4'd5, 32'd0, 32'h00001234, 32'h12340000, 1'b0, '0, '0);
    issue(8, 4'd9, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b0, '0, '0);
    issue(9, 4'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, '0, '0);
    issue(10, 4'd15, 32'd1, 32'd1, 32'd0, 1'b0, '0, '0);

    // MULT -3*7 latency and busy window
    issue(11, 4'd3, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    chk("mul_busy_cycles", cycles, 32'd33);
    chk("mul_done_at_idle", {31'b0, done}, 32'd1);
    @(negedge clk);
    issue(12, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd0, 32'd1);
    wait_idle(12);

    // signed division cases
    issue(13, 4'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_idle(13);
    issue(14, 4'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 32'd1, 32'hFFFFFFFD);
    wait_idle(14);
    issue(15, 4'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32'd0, 32'h80000000);
    wait_idle(15);
    issue(16, 4'd4, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b1, 32'd9, 32'hFFFFFFFF);
    wait_idle(16);

    // simple op after DIV keeps hi/lo
    issue(17, 4'd1, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, '0, '0);

    // starts while busy are ignored; next op right after done is accepted
    issue(18, 4'd3, 32'd5, 32'd6, 32'd30, 1'b1, 32'd0, 32'd30);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      start = 1'b1;
      alu_sel = n[3:0];
      op_a = $urandom;
      op_b = $urandom;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("mul_ignore_timeout", {31'b0, n < 200}, 32'd1);
    issue(19, 4'd2, 32'd100, 32'd23, 32'd123, 1'b0, '0, '0);
    chk("post_done_accept", {31'b0, done}, 32'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
